// File: rtl/hazard_pkg.sv
// Shared decode tables for the hazard unit: opcode/funct constants, bypass select codes,
// Tuse/Tnew encoding and a single-instruction decoder reused for every pipeline stage.
package hazard_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [1:0] FWD_PIPE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    localparam int T_W = 2;
    typedef logic [T_W-1:0] t_time_t;

    localparam int DEF_MULT_CYC = 5;
    localparam int DEF_DIV_CYC  = 10;

    typedef struct packed {
        logic    rs_rd;
        logic    rt_rd;
        t_time_t tuse_rs;
        t_time_t tuse_rt;
        t_time_t tnew_e;
        t_time_t tnew_m;
        logic    is_md;
        logic    is_md_op;
        logic    is_div;
    } dec_t;

    // Unsupported encodings fall through with nothing read and Tnew 0, so they never stall.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        d  = '0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        d.rs_rd = 1'b1; d.rt_rd = 1'b1;
                        d.tuse_rs = 2'd1; d.tuse_rt = 2'd1;
                        d.tnew_e = 2'd1;
                    end
                    FN_JR: d.rs_rd = 1'b1;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        d.rs_rd = 1'b1; d.rt_rd = 1'b1;
                        d.tuse_rs = 2'd1; d.tuse_rt = 2'd1;
                        d.is_md = 1'b1; d.is_md_op = 1'b1;
                        d.is_div = (fn == FN_DIV) || (fn == FN_DIVU);
                    end
                    FN_MFHI, FN_MFLO: begin
                        d.is_md = 1'b1;
                        d.tnew_e = 2'd1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        d.rs_rd = 1'b1; d.tuse_rs = 2'd1;
                        d.is_md = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_BEQ: begin
                d.rs_rd = 1'b1; d.rt_rd = 1'b1;
            end
            OP_ORI: begin
                d.rs_rd = 1'b1; d.tuse_rs = 2'd1;
                d.tnew_e = 2'd1;
            end
            OP_LUI: d.tnew_e = 2'd1;
            OP_LW: begin
                d.rs_rd = 1'b1; d.tuse_rs = 2'd1;
                d.tnew_e = 2'd2; d.tnew_m = 2'd1;
            end
            OP_SW: begin
                d.rs_rd = 1'b1; d.rt_rd = 1'b1;
                d.tuse_rs = 2'd1; d.tuse_rt = 2'd2;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic src_stall(input logic rd, input logic [4:0] src, input t_time_t tuse,
                                       input logic [4:0] wa_e, input t_time_t tnew_e,
                                       input logic [4:0] wa_m, input t_time_t tnew_m);
        return rd && (src != 5'd0) &&
               (((src == wa_e) && (tuse < tnew_e)) || ((src == wa_m) && (tuse < tnew_m)));
    endfunction

    // M is the nearer producer, so it wins over W when both match.
    function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] src,
                                           input logic [4:0] wa_m, input logic m_ok,
                                           input logic [4:0] wa_w);
        logic [1:0] sel;
        sel = FWD_PIPE;
        if (rd && (src != 5'd0)) begin
            if ((src == wa_m) && m_ok)
                sel = FWD_M;
            else if (src == wa_w)
                sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy counter for the multiply/divide unit; busy is a register-only output, and
// reset clears it asynchronously without waiting for a clock edge.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (start)
            r_count <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign busy = (r_count != '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/bypass controller; all outputs are combinational from the stage
// instructions, with the MD busy counter as the only state.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    input  logic [31:0] Instr_E,
    input  logic [31:0] Instr_M,
    input  logic [4:0]  GPR_WA_E,
    input  logic [4:0]  GPR_WA_M,
    input  logic [4:0]  GPR_WA_W,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IDEX_CLR,
    output logic [1:0]  FWD_RS_D,
    output logic [1:0]  FWD_RT_D,
    output logic [1:0]  FWD_RS_E,
    output logic [1:0]  FWD_RT_E,
    output logic        FWD_RT_M,
    output logic        md_start,
    output logic        md_busy
);

    dec_t       w_dec_d;
    dec_t       w_dec_e;
    dec_t       w_dec_m;
    logic [4:0] w_rs_d;
    logic [4:0] w_rt_d;
    logic [4:0] w_rs_e;
    logic [4:0] w_rt_e;
    logic [4:0] w_rt_m;
    logic       w_m_ok;
    logic       w_stall_data;
    logic       w_stall_md;
    logic       w_stall;
    logic [1:0] w_rt_m_sel;

    assign w_dec_d = decode(Instr_D);
    assign w_dec_e = decode(Instr_E);
    assign w_dec_m = decode(Instr_M);

    assign w_rs_d = Instr_D[25:21];
    assign w_rt_d = Instr_D[20:16];
    assign w_rs_e = Instr_E[25:21];
    assign w_rt_e = Instr_E[20:16];
    assign w_rt_m = Instr_M[20:16];

    assign w_stall_data =
        src_stall(w_dec_d.rs_rd, w_rs_d, w_dec_d.tuse_rs, GPR_WA_E, w_dec_e.tnew_e, GPR_WA_M, w_dec_m.tnew_m) |
        src_stall(w_dec_d.rt_rd, w_rt_d, w_dec_d.tuse_rt, GPR_WA_E, w_dec_e.tnew_e, GPR_WA_M, w_dec_m.tnew_m);

    // A start in this very cycle makes the unit occupied from the next edge on.
    assign md_start   = w_dec_e.is_md_op && !md_busy;
    assign w_stall_md = w_dec_d.is_md && (md_busy || md_start);
    assign w_stall    = w_stall_data | w_stall_md;

    assign PC_EN    = !w_stall;
    assign IFID_EN  = !w_stall;
    assign IDEX_CLR = w_stall;

    // A load still in M has no data yet, so it cannot be a bypass source.
    assign w_m_ok = (w_dec_m.tnew_m == '0);

    assign FWD_RS_D   = fwd_sel(w_dec_d.rs_rd, w_rs_d, GPR_WA_M, w_m_ok, GPR_WA_W);
    assign FWD_RT_D   = fwd_sel(w_dec_d.rt_rd, w_rt_d, GPR_WA_M, w_m_ok, GPR_WA_W);
    assign FWD_RS_E   = fwd_sel(w_dec_e.rs_rd, w_rs_e, GPR_WA_M, w_m_ok, GPR_WA_W);
    assign FWD_RT_E   = fwd_sel(w_dec_e.rt_rd, w_rt_e, GPR_WA_M, w_m_ok, GPR_WA_W);
    assign w_rt_m_sel = fwd_sel(w_dec_m.rt_rd, w_rt_m, 5'd0, 1'b0, GPR_WA_W);
    assign FWD_RT_M   = (w_rt_m_sel == FWD_W);

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (w_dec_e.is_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a table of combinational stall/bypass vectors followed by
// clocked sequences for the MD busy window and asynchronous reset.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_D, Instr_E, Instr_M;
    logic [4:0]  GPR_WA_E, GPR_WA_M, GPR_WA_W;
    logic        PC_EN, IFID_EN, IDEX_CLR, FWD_RT_M, md_start, md_busy;
    logic [1:0]  FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .Instr_D(Instr_D), .Instr_E(Instr_E), .Instr_M(Instr_M),
        .GPR_WA_E(GPR_WA_E), .GPR_WA_M(GPR_WA_M), .GPR_WA_W(GPR_WA_W),
        .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IDEX_CLR(IDEX_CLR),
        .FWD_RS_D(FWD_RS_D), .FWD_RT_D(FWD_RT_D), .FWD_RS_E(FWD_RS_E), .FWD_RT_E(FWD_RT_E),
        .FWD_RT_M(FWD_RT_M), .md_start(md_start), .md_busy(md_busy)
    );

    typedef struct {
        string       name;
        logic [31:0] d, e, m;
        int          wae, wam, waw;
        logic        s;
        logic [1:0]  rsd, rtd, rse, rte;
        logic        rtm;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] rfmt(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] ifmt(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0004};
    endfunction

    localparam logic [31:0] NOP = 32'h0;
    localparam logic [31:0] JAL = {6'h03, 26'h0000040};

    function automatic logic [13:0] mk(input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                                       input logic [1:0] rse, input logic [1:0] rte,
                                       input logic rtm, input logic st, input logic bz);
        return {~s, ~s, s, rsd, rtd, rse, rte, rtm, st, bz};
    endfunction

    task automatic set_in(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                          input int wae, input int wam, input int waw);
        Instr_D  = d;
        Instr_E  = e;
        Instr_M  = m;
        GPR_WA_E = 5'(wae);
        GPR_WA_M = 5'(wam);
        GPR_WA_W = 5'(waw);
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {PC_EN, IFID_EN, IDEX_CLR, FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E,
               FWD_RT_M, md_start, md_busy};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (pc,ifid,clr,rsd,rtd,rse,rte,rtm,start,busy)",
                     name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input int wae, input int wam, input int waw,
                       input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                       input logic [1:0] rse, input logic [1:0] rte, input logic rtm);
        vec_t v;
        v.name = name; v.d = d; v.e = e; v.m = m;
        v.wae = wae; v.wam = wam; v.waw = waw;
        v.s = s; v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte; v.rtm = rtm;
        tv.push_back(v);
    endtask

    initial begin
        // name, D, E, M, waE, waM, waW, stall, rsd, rtd, rse, rte, rtm
        add("all_nop",        NOP, NOP, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lw_E_addu_D",    rfmt(1, 3, 2, 'h21), ifmt('h23, 5, 1), NOP, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add("lw_M_addu_D",    rfmt(1, 3, 2, 'h21), NOP, ifmt('h23, 5, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add("lw_W_addu_E",    NOP, rfmt(1, 3, 2, 'h21), NOP, 2, 0, 1, 0, 0, 0, 2, 0, 0);
        add("addu_M_beq_D",   ifmt('h04, 4, 0), NOP, rfmt(5, 6, 4, 'h21), 0, 4, 0, 0, 1, 0, 0, 0, 0);
        add("addu_E_beq_D",   ifmt('h04, 4, 0), rfmt(5, 6, 4, 'h21), NOP, 4, 0, 0, 1, 0, 0, 0, 0, 0);
        add("jal_E_jr_D",     rfmt(31, 0, 0, 'h08), JAL, NOP, 31, 0, 0, 0, 0, 0, 0, 0, 0);
        add("jal_M_jr_D",     rfmt(31, 0, 0, 'h08), NOP, JAL, 0, 31, 0, 0, 1, 0, 0, 0, 0);
        add("r0_no_fwd",      NOP, rfmt(0, 3, 2, 'h21), rfmt(1, 2, 0, 'h21), 2, 0, 3, 0, 0, 0, 0, 2, 0);
        add("sw_E_M_over_W",  NOP, ifmt('h2b, 8, 7), rfmt(1, 2, 7, 'h21), 0, 7, 8, 0, 0, 0, 2, 1, 0);
        add("sw_M_fwd_W",     NOP, NOP, ifmt('h2b, 10, 9), 0, 0, 9, 0, 0, 0, 0, 0, 1);
        add("sw_rt_tuse2",    ifmt('h2b, 2, 1), ifmt('h23, 5, 1), NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("sw_rs_lw_E",     ifmt('h2b, 2, 1), ifmt('h23, 5, 2), NOP, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        add("lw_M_ori_D",     ifmt('h0d, 2, 3), NOP, ifmt('h23, 5, 2), 0, 2, 0, 0, 0, 0, 0, 0, 0);
        add("mthi_idle_fwdW", rfmt(5, 0, 0, 'h11), NOP, NOP, 0, 0, 5, 0, 2, 0, 0, 0, 0);
        add("mfhi_E_beq_D",   ifmt('h04, 7, 0), rfmt(0, 0, 7, 'h10), NOP, 7, 0, 0, 1, 0, 0, 0, 0, 0);
        add("mfhi_E_addu_D",  rfmt(7, 8, 6, 'h21), rfmt(0, 0, 7, 'h10), NOP, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        add("mfhi_M_rt_D",    rfmt(7, 8, 6, 'h21), NOP, rfmt(0, 0, 8, 'h10), 0, 8, 0, 0, 0, 1, 0, 0, 0);
        add("lw_r0_no_stall", rfmt(0, 0, 1, 'h21), ifmt('h23, 5, 0), NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("unsupported_D",  ifmt('h08, 1, 2), ifmt('h23, 5, 1), NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("lui_M_beq_rt",   ifmt('h04, 0, 4), NOP, ifmt('h0f, 0, 4), 0, 4, 0, 0, 0, 1, 0, 0, 0);

        reset = 1'b1;
        set_in(NOP, NOP, NOP, 0, 0, 0);
        #2;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        foreach (tv[i]) begin
            @(posedge clk); #1;
            set_in(tv[i].d, tv[i].e, tv[i].m, tv[i].wae, tv[i].wam, tv[i].waw);
            @(negedge clk);
            check(tv[i].name, mk(tv[i].s, tv[i].rsd, tv[i].rtd, tv[i].rse, tv[i].rte, tv[i].rtm, 1'b0, 1'b0));
        end

        // div in E with mflo waiting in D; a mult arriving mid-window must not restart the unit
        @(posedge clk); #1;
        set_in(rfmt(0, 0, 2, 'h12), rfmt(3, 4, 0, 'h1a), NOP, 0, 0, 0);
        @(negedge clk);
        check("div_start", mk(1, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            set_in(rfmt(0, 0, 2, 'h12), (k == 3) ? rfmt(5, 6, 0, 'h18) : NOP, NOP, 0, 0, 0);
            @(negedge clk);
            check($sformatf("div_busy_%0d", k), mk(1, 0, 0, 0, 0, 0, 0, 1));
        end
        @(posedge clk); #1;
        set_in(rfmt(0, 0, 2, 'h12), NOP, NOP, 0, 0, 0);
        @(negedge clk);
        check("div_release", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // mult: busy for five cycles, mflo passes on the sixth
        @(posedge clk); #1;
        set_in(NOP, rfmt(5, 6, 0, 'h19), NOP, 0, 0, 0);
        @(negedge clk);
        check("mult_start", mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            set_in(NOP, NOP, NOP, 0, 0, 0);
            @(negedge clk);
            check($sformatf("mult_busy_%0d", k), mk(0, 0, 0, 0, 0, 0, 0, 1));
        end
        @(posedge clk); #1;
        set_in(rfmt(0, 0, 2, 'h12), NOP, NOP, 0, 0, 0);
        @(negedge clk);
        check("mult_done_mflo", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // asynchronous reset in the third busy cycle of a div
        @(posedge clk); #1;
        set_in(NOP, rfmt(3, 4, 0, 'h1b), NOP, 0, 0, 0);
        @(negedge clk);
        check("divu_start", mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            set_in(NOP, NOP, NOP, 0, 0, 0);
        end
        check("rst_pre_busy", mk(0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;
        #1;
        check("rst_mid_count", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_after", mk(0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
